// File: rtl/led_event_status.sv
// Board status LED event indicator.
// Each channel edge-detects its event input and shows it as sticky, stretched,
// blinking-sticky or disabled. It also keeps a saturating 8-bit event count.
// LED bits above the channels show a free-running heartbeat counter.
module led_event_status #(
   parameter int NUM_CH      = 4,
   parameter int LED_W       = 8,
   parameter int HB_W        = 30,
   parameter int HB_MSB      = 25,
   parameter int BLINK_BIT   = 22,
   parameter int STRETCH_CYC = 1000000
) (
   input  logic                  clk_100m,
   input  logic                  reset,
   input  logic [NUM_CH-1:0]     ev_in,
   input  logic [NUM_CH-1:0]     ev_clr,
   input  logic [2*NUM_CH-1:0]   ev_mode,
   output logic [NUM_CH-1:0]     ev_held,
   output logic [8*NUM_CH-1:0]   ev_cnt,
   output logic [LED_W-1:0]      led
);

   localparam int SCNT_W = $clog2(STRETCH_CYC + 1);
   localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(STRETCH_CYC - 1);

   typedef enum logic {IDLE, HELD} ch_state_t;

   logic [NUM_CH-1:0] ev_d;
   logic [NUM_CH-1:0] rise;
   logic [HB_W-1:0]   hb_cnt;
   logic [NUM_CH-1:0] led_ch;

   ch_state_t         state     [NUM_CH];
   logic [SCNT_W-1:0] scnt      [NUM_CH];
   ch_state_t         state_nxt [NUM_CH];
   logic [SCNT_W-1:0] scnt_nxt  [NUM_CH];
   logic [7:0]        cnt_nxt   [NUM_CH];
   logic [NUM_CH-1:0] led_nxt;

   // Per-channel next state, stretch counter, event count and LED bit
   always_comb begin
      rise = ev_in & ~ev_d;
      for (int c = 0; c < NUM_CH; c++) begin
         state_nxt[c] = state[c];
         scnt_nxt[c]  = scnt[c];
         cnt_nxt[c]   = ev_cnt[8*c +: 8];
         led_nxt[c]   = 1'b0;

         case (ev_mode[2*c +: 2])
            2'd3: begin
               // Disabled: drop any indication and ignore edges
               state_nxt[c] = IDLE;
               scnt_nxt[c]  = '0;
            end
            2'd1: begin
               // Stretch: a new edge always reloads, even over a clear
               if (rise[c]) begin
                  state_nxt[c] = HELD;
                  scnt_nxt[c]  = SCNT_LOAD;
               end else if (ev_clr[c]) begin
                  state_nxt[c] = IDLE;
                  scnt_nxt[c]  = '0;
               end else if (state[c] == HELD) begin
                  if (scnt[c] == '0) state_nxt[c] = IDLE;
                  else               scnt_nxt[c] = scnt[c] - SCNT_W'(1);
               end
            end
            default: begin
               // Sticky and blink-sticky: set wins over clear; counter parked at 0
               if (rise[c])        state_nxt[c] = HELD;
               else if (ev_clr[c]) state_nxt[c] = IDLE;
               scnt_nxt[c] = '0;
            end
         endcase

         if (ev_clr[c]) begin
            cnt_nxt[c] = (rise[c] && ev_mode[2*c +: 2] != 2'd3) ? 8'd1 : 8'd0;
         end else if (rise[c] && ev_mode[2*c +: 2] != 2'd3 && cnt_nxt[c] != 8'hFF) begin
            cnt_nxt[c] = cnt_nxt[c] + 8'd1;
         end

         case (ev_mode[2*c +: 2])
            2'd0, 2'd1: led_nxt[c] = (state_nxt[c] == HELD);
            2'd2:       led_nxt[c] = (state_nxt[c] == HELD) & hb_cnt[BLINK_BIT];
            default:    led_nxt[c] = 1'b0;
         endcase
      end
   end

   // Channel FSMs, edge-detect history, counts, heartbeat and channel LED register
   always_ff @(posedge clk_100m) begin
      if (reset) begin
         ev_d    <= '0;
         hb_cnt  <= '0;
         ev_held <= '0;
         ev_cnt  <= '0;
         led_ch  <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            state[c] <= IDLE;
            scnt[c]  <= '0;
         end
      end else begin
         ev_d   <= ev_in;
         hb_cnt <= hb_cnt + HB_W'(1);
         led_ch <= led_nxt;
         for (int c = 0; c < NUM_CH; c++) begin
            state[c]         <= state_nxt[c];
            scnt[c]          <= scnt_nxt[c];
            ev_held[c]       <= (state_nxt[c] == HELD);
            ev_cnt[8*c +: 8] <= cnt_nxt[c];
         end
      end
   end

   generate
      if (LED_W > NUM_CH) begin : g_hb
         logic [LED_W-NUM_CH-1:0] led_hb;

         // Heartbeat LEDs trail the heartbeat counter by one cycle
         always_ff @(posedge clk_100m) begin
            if (reset) led_hb <= '0;
            else       led_hb <= hb_cnt[HB_MSB -: (LED_W - NUM_CH)];
         end

         assign led = {led_hb, led_ch};
      end else begin : g_no_hb
         assign led = led_ch;
      end
   endgenerate

endmodule

// File: tb/tb_led_event_status.sv
// Scoreboard bench for led_event_status.
// Stimulus drives a behavioural model that queues the expected outputs.
// A monitor compares every registered output word against the queue.
module tb_led_event_status;
   localparam int NUM_CH      = 4;
   localparam int LED_W       = 8;
   localparam int HB_W        = 4;
   localparam int HB_MSB      = 3;
   localparam int BLINK_BIT   = 2;
   localparam int STRETCH_CYC = 5;

   logic                 clk_100m = 1'b0;
   logic                 reset    = 1'b1;
   logic [NUM_CH-1:0]    ev_in    = '0;
   logic [NUM_CH-1:0]    ev_clr   = '0;
   logic [2*NUM_CH-1:0]  ev_mode  = '0;
   logic [NUM_CH-1:0]    ev_held;
   logic [8*NUM_CH-1:0]  ev_cnt;
   logic [LED_W-1:0]     led;

   led_event_status #(
      .NUM_CH(NUM_CH), .LED_W(LED_W), .HB_W(HB_W), .HB_MSB(HB_MSB),
      .BLINK_BIT(BLINK_BIT), .STRETCH_CYC(STRETCH_CYC)
   ) dut (
      .clk_100m(clk_100m), .reset(reset), .ev_in(ev_in), .ev_clr(ev_clr),
      .ev_mode(ev_mode), .ev_held(ev_held), .ev_cnt(ev_cnt), .led(led)
   );

   always #5 clk_100m = ~clk_100m;

   typedef struct packed {
      logic [NUM_CH-1:0]   held;
      logic [8*NUM_CH-1:0] cnt;
      logic [LED_W-1:0]    led;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_errors = 0;

   // Reference model: plain integers per channel
   int m_held [NUM_CH];
   int m_rem  [NUM_CH];
   int m_cnt  [NUM_CH];
   int m_prev [NUM_CH];
   int m_hb = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      exp_t e;
      int   m;
      bit   r, k, lit;
      e = '0;
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_held[c] = 0; m_rem[c] = 0; m_cnt[c] = 0; m_prev[c] = 0;
         end
         m_hb = 0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            m = int'(ev_mode[2*c +: 2]);
            r = ev_in[c] && (m_prev[c] == 0);
            k = ev_clr[c];
            if (m == 3) begin
               m_held[c] = 0;
               m_rem[c]  = 0;
               if (k) m_cnt[c] = 0;
            end else begin
               if (k)      m_cnt[c] = r ? 1 : 0;
               else if (r) m_cnt[c] = (m_cnt[c] >= 255) ? 255 : m_cnt[c] + 1;
               if (m == 1) begin
                  if (r) begin
                     m_held[c] = 1; m_rem[c] = STRETCH_CYC - 1;
                  end else if (k) begin
                     m_held[c] = 0; m_rem[c] = 0;
                  end else if (m_held[c] != 0) begin
                     if (m_rem[c] == 0) m_held[c] = 0;
                     else               m_rem[c] = m_rem[c] - 1;
                  end
               end else begin
                  if (r)      m_held[c] = 1;
                  else if (k) m_held[c] = 0;
                  m_rem[c] = 0;
               end
            end
            lit = (m_held[c] != 0) &&
                  (m == 0 || m == 1 || (m == 2 && ((m_hb >> BLINK_BIT) & 1) == 1));
            e.held[c]        = (m_held[c] != 0);
            e.cnt[8*c +: 8]  = 8'(m_cnt[c]);
            e.led[c]         = lit;
            m_prev[c]        = ev_in[c] ? 1 : 0;
         end
         e.led[LED_W-1:NUM_CH] = 4'(m_hb % 16);
         m_hb = (m_hb + 1) % 16;
      end
      sbq.push_back(e);
   endtask

   // Apply one cycle of stimulus and queue the response it should produce
   task automatic cycle(input logic r, input logic [3:0] in, input logic [3:0] clr,
                        input logic [7:0] md);
      @(posedge clk_100m);
      #2;
      reset   = r;
      ev_in   = in;
      ev_clr  = clr;
      ev_mode = md;
      model_step();
   endtask

   // Monitor: every cycle after reset, one output word is due
   always @(posedge clk_100m) begin
      #1;
      if (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         chk("sb_held", 32'(ev_held), 32'(mon_e.held));
         chk("sb_cnt",  ev_cnt,       mon_e.cnt);
         chk("sb_led",  32'(led),     32'(mon_e.led));
      end
   end

   initial begin
      int hcount;
      logic [7:0] md;
      logic [3:0] rin, rclr;
      logic       rrst;

      md = 8'h00;
      // Input held high through reset release counts once
      repeat (3) cycle(1'b1, 4'b0001, 4'b0000, md);
      cycle(1'b0, 4'b0001, 4'b0000, md);
      cycle(1'b0, 4'b0001, 4'b0000, md);
      chk("rst_release_cnt0",  32'(ev_cnt[7:0]), 32'd1);
      chk("rst_release_held0", 32'(ev_held[0]),  32'd1);

      // Sticky clear, then a new edge
      cycle(1'b0, 4'b0001, 4'b0001, md);
      cycle(1'b0, 4'b0000, 4'b0000, md);
      chk("sticky_clr_held0", 32'(ev_held[0]),  32'd0);
      chk("sticky_clr_cnt0",  32'(ev_cnt[7:0]), 32'd0);
      cycle(1'b0, 4'b0001, 4'b0000, md);
      cycle(1'b0, 4'b0000, 4'b0000, md);
      chk("sticky_set_held0", 32'(ev_held[0]), 32'd1);

      // Edge and clear in the same cycle
      cycle(1'b0, 4'b0010, 4'b0000, md);
      cycle(1'b0, 4'b0000, 4'b0000, md);
      cycle(1'b0, 4'b0010, 4'b0010, md);
      cycle(1'b0, 4'b0000, 4'b0000, md);
      chk("collide_held1", 32'(ev_held[1]),   32'd1);
      chk("collide_cnt1",  32'(ev_cnt[15:8]), 32'd1);

      // Stretch on channel 2
      md = 8'h10;
      cycle(1'b0, 4'b0100, 4'b0000, md);
      hcount = 0;
      repeat (12) begin
         cycle(1'b0, 4'b0000, 4'b0000, md);
         hcount += int'(ev_held[2]);
      end
      chk("stretch_len", 32'(hcount), 32'd5);

      // Retrigger during the third held cycle
      cycle(1'b0, 4'b0100, 4'b0000, md);
      hcount = 0;
      cycle(1'b0, 4'b0000, 4'b0000, md); hcount += int'(ev_held[2]);
      cycle(1'b0, 4'b0000, 4'b0000, md); hcount += int'(ev_held[2]);
      cycle(1'b0, 4'b0100, 4'b0000, md); hcount += int'(ev_held[2]);
      repeat (14) begin
         cycle(1'b0, 4'b0000, 4'b0000, md);
         hcount += int'(ev_held[2]);
      end
      chk("retrigger_len", 32'(hcount), 32'd8);

      // Count saturation on channel 3
      repeat (300) begin
         cycle(1'b0, 4'b1000, 4'b0000, md);
         cycle(1'b0, 4'b0000, 4'b0000, md);
      end
      chk("sat_cnt3",  32'(ev_cnt[31:24]), 32'd255);
      chk("sat_held3", 32'(ev_held[3]),    32'd1);

      // Disabled channel ignores edges
      md = 8'hD0;
      repeat (10) begin
         cycle(1'b0, 4'b1000, 4'b0000, md);
         cycle(1'b0, 4'b0000, 4'b0000, md);
      end
      chk("dis_cnt3",  32'(ev_cnt[31:24]), 32'd255);
      chk("dis_held3", 32'(ev_held[3]),    32'd0);
      chk("dis_led3",  32'(led[3]),        32'd0);

      // Reset in the middle of a stretch
      md = 8'h10;
      cycle(1'b0, 4'b0100, 4'b0000, md);
      cycle(1'b0, 4'b0000, 4'b0000, md);
      cycle(1'b1, 4'b0000, 4'b0000, md);
      cycle(1'b0, 4'b0000, 4'b0000, md);
      chk("midrst_held", 32'(ev_held), 32'd0);
      chk("midrst_cnt",  ev_cnt,       32'd0);
      chk("midrst_led",  32'(led),     32'd0);

      // Blink-sticky on all channels across several blink periods
      md = 8'hAA;
      cycle(1'b0, 4'b1111, 4'b0000, md);
      repeat (20) cycle(1'b0, 4'b0000, 4'b0000, md);

      // Randomised traffic
      md = 8'($urandom);
      repeat (3000) begin
         if ($urandom_range(0, 49) == 0) md = 8'($urandom);
         rin  = 4'($urandom);
         rclr = 4'($urandom & $urandom & $urandom);
         rrst = ($urandom_range(0, 299) == 0);
         cycle(rrst, rin, rclr, md);
      end

      cycle(1'b0, 4'b0000, 4'b0000, 8'h00);
      cycle(1'b0, 4'b0000, 4'b0000, 8'h00);
      @(posedge clk_100m);
      #3;
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
